// File: rtl/spi_ram_wrapper.sv
// rtl/spi_ram_wrapper.sv - SPI slave frame shifter with a MEM_DEPTH x 8 single-port RAM
module spi_ram_wrapper #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic CLK,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   bit_cnt;
    logic [9:0]   rx_data;
    logic         rx_valid;
    logic         tx_valid;
    logic [7:0]   dout;
    logic         rd_addr_seen;
    logic [7:0]   tx_shift;
    logic [2:0]   tx_cnt;
    logic         shifting;

    assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (SS_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI)            state_next = WRITE;
                    else if (rd_addr_seen) state_next = READ_DATA;
                    else                  state_next = READ_ADD;
                end
                default: state_next = state;
            endcase
        end
    end

    // Bits beyond the tenth are ignored until the master releases SS_n.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 4'd0;
            rx_data  <= 10'd0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || !shifting) begin
                bit_cnt <= 4'd0;
            end else if (bit_cnt != 4'd10) begin
                rx_data  <= {rx_data[8:0], MOSI};
                bit_cnt  <= bit_cnt + 4'd1;
                rx_valid <= (bit_cnt == 4'd9);
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            MISO     <= 1'b0;
            tx_shift <= 8'd0;
            tx_cnt   <= 3'd0;
        end else if (SS_n) begin
            MISO     <= 1'b0;
            tx_shift <= 8'd0;
            tx_cnt   <= 3'd0;
        end else if (tx_valid) begin
            MISO     <= dout[7];
            tx_shift <= {dout[6:0], 1'b0};
            tx_cnt   <= 3'd7;
        end else if (tx_cnt != 3'd0) begin
            MISO     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
            tx_cnt   <= tx_cnt - 3'd1;
        end else begin
            MISO <= 1'b0;
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) RAM (
        .CLK         (CLK),
        .rst         (rst),
        .din         (rx_data),
        .rx_valid    (rx_valid),
        .dout        (dout),
        .tx_valid    (tx_valid),
        .rd_addr_seen(rd_addr_seen)
    );
endmodule

module spi_ram_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       rd_addr_seen
);
    logic [7:0]           RAM [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            rd_addr_seen <= 1'b0;
            tx_valid     <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (din[9:8])
                    2'b00: wr_addr <= din[ADDR_SIZE-1:0];
                    2'b10: begin
                        rd_addr      <= din[ADDR_SIZE-1:0];
                        rd_addr_seen <= 1'b1;
                    end
                    2'b11: begin
                        tx_valid     <= 1'b1;
                        rd_addr_seen <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge CLK) begin
        if (rx_valid && din[9:8] == 2'b01) RAM[wr_addr] <= din[7:0];
        if (rx_valid && din[9:8] == 2'b11) dout <= RAM[rd_addr];
    end
endmodule

// File: tb/tb_spi_ram_wrapper.sv
// tb/tb_spi_ram_wrapper.sv - directed and random frame checks for spi_ram_wrapper
module tb_spi_ram_wrapper;
    logic CLK = 1'b0;
    logic rst;
    logic MOSI;
    logic SS_n;
    logic MISO;

    int checks = 0;
    int errors = 0;
    logic [7:0] model [0:255];
    logic [7:0] sb_q [$];

    spi_ram_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) DUT (
        .CLK (CLK),
        .rst (rst),
        .MOSI(MOSI),
        .SS_n(SS_n),
        .MISO(MISO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One idle-cycle bit, the command-select bit, then the 10-bit frame.
    task automatic send(input logic sel, input logic [9:0] frame, input logic hold);
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge CLK);
        MOSI = sel;
        @(negedge CLK);
        for (int i = 9; i >= 0; i--) begin
            MOSI = frame[i];
            @(negedge CLK);
        end
        if (!hold) begin
            SS_n = 1'b1;
            MOSI = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        send(1'b0, {2'b00, a}, 1'b0);
        send(1'b0, {2'b01, d}, 1'b0);
        model[a] = d;
    endtask

    task automatic read_byte(input logic [7:0] a, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        send(1'b1, {2'b10, a}, 1'b0);
        sb_q.push_back(model[a]);
        send(1'b1, {2'b11, 8'h00}, 1'b1);
        chk({tag, "_txv_early"}, 32'(DUT.RAM.tx_valid), 32'd0);
        @(negedge CLK);
        chk({tag, "_txv_pulse"}, 32'(DUT.RAM.tx_valid), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            @(negedge CLK);
            got[i] = MISO;
            if (i == 7) chk({tag, "_txv_one_cycle"}, 32'(DUT.RAM.tx_valid), 32'd0);
        end
        @(negedge CLK);
        chk({tag, "_miso_after"}, 32'(MISO), 32'd0);
        exp = sb_q.pop_front();
        chk({tag, "_data"}, 32'(got), 32'(exp));
        SS_n = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0] ra [5];
        logic [7:0] a;
        logic [7:0] d;
        rst  = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        for (int i = 0; i < 256; i++) begin
            DUT.RAM.RAM[i] <= 8'(i) ^ 8'h5A;
            model[i] = 8'(i) ^ 8'h5A;
        end
        repeat (20) @(negedge CLK);
        chk("reset_miso", 32'(MISO), 32'd0);
        chk("reset_state", 32'(DUT.state), 32'd0);
        chk("reset_rx_valid", 32'(DUT.rx_valid), 32'd0);
        chk("reset_ram_intact", 32'(DUT.RAM.RAM[8'h10]), 32'(8'h10 ^ 8'h5A));
        rst = 1'b0;
        @(negedge CLK);
        chk("reset_wr_addr", 32'(DUT.RAM.wr_addr), 32'd0);

        send(1'b0, {2'b00, 8'h3C}, 1'b0);
        chk("wa_wr_addr", 32'(DUT.RAM.wr_addr), 32'h3C);
        chk("wa_ram_unchanged", 32'(DUT.RAM.RAM[8'h3C]), 32'(8'h3C ^ 8'h5A));

        send(1'b0, {2'b01, 8'hA5}, 1'b0);
        model[8'h3C] = 8'hA5;
        chk("wd_ram", 32'(DUT.RAM.RAM[8'h3C]), 32'hA5);

        read_byte(8'h3C, "rd_3c");

        for (int k = 0; k < 5; k++) begin
            ra[k] = 8'($urandom_range(0, 255));
            write_byte(ra[k], 8'($urandom_range(0, 255)));
        end
        for (int k = 0; k < 5; k++) read_byte(ra[k], $sformatf("rnd_rd%0d", k));

        for (int k = 0; k < 5; k++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            write_byte(a, d);
            read_byte(a, $sformatf("ilv_rd%0d", k));
        end

        send(1'b0, {2'b00, 8'h20}, 1'b0);
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        MOSI = 1'b0; @(negedge CLK);
        MOSI = 1'b1; @(negedge CLK);
        MOSI = 1'b1; @(negedge CLK);
        MOSI = 1'b1; @(negedge CLK);
        MOSI = 1'b1; @(negedge CLK);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort_ram", 32'(DUT.RAM.RAM[8'h20]), 32'(model[8'h20]));
        chk("abort_wr_addr", 32'(DUT.RAM.wr_addr), 32'h20);
        send(1'b0, {2'b01, 8'h77}, 1'b0);
        model[8'h20] = 8'h77;
        chk("abort_next_frame", 32'(DUT.RAM.RAM[8'h20]), 32'h77);
        read_byte(8'h20, "abort_rd");

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
